// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared encodings and helpers for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam logic [2:0] FWD_RF    = 3'b000;
  localparam logic [2:0] FWD_ALU_M = 3'b001;
  localparam logic [2:0] FWD_WD_W  = 3'b010;
  localparam logic [2:0] FWD_PC8_E = 3'b100;
  localparam logic [2:0] FWD_PC8_M = 3'b101;
  localparam logic [2:0] FWD_PC8_W = 3'b110;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC8 = 2'b10;

  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  localparam logic [1:0] TUSE_NEVER = 2'd3;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [1:0] src;
  } dst_rec_t;

  // Register $0 is hard-wired, so it never produces a dependency.
  function automatic logic reg_match(input logic [4:0] a3, input logic [4:0] r);
    return (r != 5'd0) && (a3 == r);
  endfunction

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module      : hazard_ctrl_if
// Description : D-stage decode info into, and forward/stall controls out of,
//               the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if;

  logic [4:0]  rs_D;
  logic [4:0]  rt_D;
  logic [1:0]  tuse_rs_D;
  logic [1:0]  tuse_rt_D;
  logic [4:0]  a3_D;
  logic [1:0]  tnew_D;
  logic [1:0]  src_D;
  logic        md_D;
  logic [1:0]  md_kind_D;

  logic        stall;
  logic [2:0]  cmpa_for;
  logic [2:0]  cmpb_for;
  logic [2:0]  ra_for;
  logic [2:0]  alua_for;
  logic [2:0]  alub_for;
  logic [2:0]  dm_wd_for;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, a3_D, tnew_D, src_D, md_D, md_kind_D,
    input  stall, cmpa_for, cmpb_for, ra_for, alua_for, alub_for, dm_wd_for,
    input  md_busy, stall_cnt
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, a3_D, tnew_D, src_D, md_D, md_kind_D,
    output stall, cmpa_for, cmpb_for, ra_for, alua_for, alub_for, dm_wd_for,
    output md_busy, stall_cnt
  );

endinterface

`default_nettype wire

// File: rtl/md_busy_tracker.sv
// ============================================================================
// Module      : md_busy_tracker
// Description : Mult/div busy down-counter loaded as a mult/div leaves E.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic [1:0] md_kind_i,
  output logic            busy_o
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case (md_kind_i)
      MD_MULT: cnt_d = CNT_W'(MULT_CYCLES);
      MD_DIV:  cnt_d = CNT_W'(DIV_CYCLES);
      default: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall and forward-select generation for the 5-stage pipeline.
//               Define HAZARD_PERF_EN to build the stall_cnt counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input wire logic    clk,
  input wire logic    reset,
  hazard_ctrl_if.slave bus
);

  dst_rec_t   e_q, e_d, m_q, m_d;
  logic [4:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d;
  logic [4:0] rt_m_q, rt_m_d, a3_w_q, a3_w_d;
  logic [1:0] src_w_q, src_w_d, md_kind_e_q, md_kind_e_d;
  logic       w_md_busy;
  logic       w_stall;

  function automatic logic raw_hazard(
    input logic [4:0] r, input logic [1:0] tuse,
    input logic [4:0] e_a3, input logic [1:0] e_tnew,
    input logic [4:0] m_a3, input logic [1:0] m_tnew
  );
    if (tuse == TUSE_NEVER) return 1'b0;
    return (reg_match(e_a3, r) && (tuse < e_tnew)) ||
           (reg_match(m_a3, r) && (tuse < m_tnew));
  endfunction

  // The youngest matching producer wins; if its value is not ready yet the
  // select stays at FWD_RF and the stall holds the consumer in D.
  function automatic logic [2:0] fwd_d(
    input logic [4:0] r,
    input logic [4:0] e_a3, input logic [1:0] e_tnew, input logic [1:0] e_src,
    input logic [4:0] m_a3, input logic [1:0] m_tnew, input logic [1:0] m_src,
    input logic [4:0] w_a3, input logic [1:0] w_src
  );
    logic [2:0] sel;
    sel = FWD_RF;
    if (reg_match(e_a3, r)) begin
      if ((e_tnew == 2'd0) && (e_src == SRC_PC8)) sel = FWD_PC8_E;
    end else if (reg_match(m_a3, r)) begin
      if (m_tnew == 2'd0) begin
        if (m_src == SRC_ALU)      sel = FWD_ALU_M;
        else if (m_src == SRC_PC8) sel = FWD_PC8_M;
      end
    end else if (reg_match(w_a3, r)) begin
      sel = (w_src == SRC_PC8) ? FWD_PC8_W : FWD_WD_W;
    end
    return sel;
  endfunction

  function automatic logic [2:0] fwd_e(
    input logic [4:0] r,
    input logic [4:0] m_a3, input logic [1:0] m_src,
    input logic [4:0] w_a3
  );
    logic [2:0] sel;
    sel = FWD_RF;
    if (reg_match(m_a3, r)) begin
      case (m_src)
        SRC_ALU: sel = FWD_ALU_M;
        SRC_PC8: sel = FWD_PC8_M;
        SRC_MEM: sel = FWD_RF;
        default: sel = FWD_RF;
      endcase
    end else if (reg_match(w_a3, r)) begin
      sel = FWD_WD_W;
    end
    return sel;
  endfunction

  always_comb begin
    w_stall = raw_hazard(bus.rs_D, bus.tuse_rs_D, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew) ||
              raw_hazard(bus.rt_D, bus.tuse_rt_D, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew) ||
              (bus.md_D && (w_md_busy || (md_kind_e_q != MD_NONE)));
  end

  always_comb begin
    e_d         = '0;
    rs_e_d      = '0;
    rt_e_d      = '0;
    md_kind_e_d = MD_NONE;
    if (!w_stall) begin
      e_d.a3      = bus.a3_D;
      e_d.tnew    = bus.tnew_D;
      e_d.src     = bus.src_D;
      rs_e_d      = bus.rs_D;
      rt_e_d      = bus.rt_D;
      md_kind_e_d = bus.md_kind_D;
    end
    m_d.a3   = e_q.a3;
    m_d.tnew = tnew_dec(e_q.tnew);
    m_d.src  = e_q.src;
    rt_m_d   = rt_e_q;
    a3_w_d   = m_q.a3;
    src_w_d  = m_q.src;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q         <= '0;
      m_q         <= '0;
      rs_e_q      <= '0;
      rt_e_q      <= '0;
      rt_m_q      <= '0;
      a3_w_q      <= '0;
      src_w_q     <= SRC_ALU;
      md_kind_e_q <= MD_NONE;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      rs_e_q      <= rs_e_d;
      rt_e_q      <= rt_e_d;
      rt_m_q      <= rt_m_d;
      a3_w_q      <= a3_w_d;
      src_w_q     <= src_w_d;
      md_kind_e_q <= md_kind_e_d;
    end
  end

  md_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy (
    .clk       (clk),
    .reset     (reset),
    .md_kind_i (md_kind_e_q),
    .busy_o    (w_md_busy)
  );

  assign bus.stall     = w_stall;
  assign bus.md_busy   = w_md_busy;
  assign bus.cmpa_for  = fwd_d(bus.rs_D, e_q.a3, e_q.tnew, e_q.src,
                               m_q.a3, m_q.tnew, m_q.src, a3_w_q, src_w_q);
  assign bus.cmpb_for  = fwd_d(bus.rt_D, e_q.a3, e_q.tnew, e_q.src,
                               m_q.a3, m_q.tnew, m_q.src, a3_w_q, src_w_q);
  assign bus.ra_for    = bus.cmpa_for;
  assign bus.alua_for  = fwd_e(rs_e_q, m_q.a3, m_q.src, a3_w_q);
  assign bus.alub_for  = fwd_e(rt_e_q, m_q.a3, m_q.src, a3_w_q);
  assign bus.dm_wd_for = reg_match(a3_w_q, rt_m_q) ? FWD_WD_W : FWD_RF;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)        stall_cnt_q <= '0;
    else if (w_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed and random stimulus for hazard_ctrl against an
//               instruction-level pipeline model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [1:0] src;
    logic       md;
    logic [1:0] kind;
  } d_t;

  logic clk;
  logic reset;
  hazard_ctrl_if bus ();

  hazard_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pipe[0]=E, pipe[1]=M, pipe[2]=W, each holding the instruction as issued.
  d_t          pipe [3];
  int          cyc = 0;
  int          busy_until = 0;
  logic [31:0] perf = '0;
  d_t          cur_d;
  logic        cur_rst;
  logic        cur_stall;
  int          busy_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic d_t mk(input int rs, input int rt, input int tu_rs, input int tu_rt,
                            input int a3, input int tnew, input logic [1:0] src,
                            input logic md, input logic [1:0] kind);
    d_t d;
    d.rs = 5'(rs); d.rt = 5'(rt); d.tuse_rs = 2'(tu_rs); d.tuse_rt = 2'(tu_rt);
    d.a3 = 5'(a3); d.tnew = 2'(tnew); d.src = src; d.md = md; d.kind = kind;
    return d;
  endfunction

  function automatic d_t rand_inst();
    d_t d;
    d = '0;
    d.rs = 5'($urandom_range(0, 3));
    d.rt = 5'($urandom_range(0, 3));
    d.tuse_rs = 2'($urandom_range(0, 3));
    d.tuse_rt = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0, 1, 2: begin d.a3 = 5'($urandom_range(0, 3)); d.tnew = 2'd1; d.src = SRC_ALU; end
      3, 4:    begin d.a3 = 5'($urandom_range(0, 3)); d.tnew = 2'd2; d.src = SRC_MEM; end
      5:       begin d.a3 = 5'($urandom_range(1, 3)); d.tnew = 2'd0; d.src = SRC_PC8; end
      6:       d.a3 = 5'd0;
      7:       begin d.md = 1'b1; d.kind = MD_MULT; end
      8:       begin d.md = 1'b1; d.kind = MD_DIV; end
      default: begin d.md = 1'b1; d.a3 = 5'($urandom_range(0, 3)); d.tnew = 2'd1; end
    endcase
    return d;
  endfunction

  // Cycles left before the result of the instruction in stage i is available.
  function automatic int rem(input int i);
    int t;
    t = int'(pipe[i].tnew) - i;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic logic [2:0] exp_fwd_d(input logic [4:0] r);
    if (r == 5'd0) return FWD_RF;
    if (pipe[0].a3 == r)
      return (rem(0) == 0 && pipe[0].src == SRC_PC8) ? FWD_PC8_E : FWD_RF;
    if (pipe[1].a3 == r) begin
      if (rem(1) != 0) return FWD_RF;
      if (pipe[1].src == SRC_ALU) return FWD_ALU_M;
      if (pipe[1].src == SRC_PC8) return FWD_PC8_M;
      return FWD_RF;
    end
    if (pipe[2].a3 == r) return (pipe[2].src == SRC_PC8) ? FWD_PC8_W : FWD_WD_W;
    return FWD_RF;
  endfunction

  function automatic logic [2:0] exp_fwd_e(input logic [4:0] r);
    if (r == 5'd0) return FWD_RF;
    if (pipe[1].a3 == r) begin
      if (pipe[1].src == SRC_ALU) return FWD_ALU_M;
      if (pipe[1].src == SRC_PC8) return FWD_PC8_M;
      return FWD_RF;
    end
    if (pipe[2].a3 == r) return FWD_WD_W;
    return FWD_RF;
  endfunction

  function automatic logic exp_stall(input d_t d);
    logic s;
    s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (d.rs != 0 && pipe[i].a3 == d.rs && int'(d.tuse_rs) < rem(i)) s = 1'b1;
      if (d.rt != 0 && pipe[i].a3 == d.rt && int'(d.tuse_rt) < rem(i)) s = 1'b1;
    end
    if (d.md && (cyc < busy_until || pipe[0].kind != MD_NONE)) s = 1'b1;
    return s;
  endfunction

  task automatic apply_check(input d_t d, input logic rst);
    logic        s;
    logic [31:0] exp_cnt;
    @(negedge clk);
    bus.rs_D = d.rs; bus.rt_D = d.rt;
    bus.tuse_rs_D = d.tuse_rs; bus.tuse_rt_D = d.tuse_rt;
    bus.a3_D = d.a3; bus.tnew_D = d.tnew; bus.src_D = d.src;
    bus.md_D = d.md; bus.md_kind_D = d.kind;
    reset = rst;
    #1;
    s = exp_stall(d);
`ifdef HAZARD_PERF_EN
    exp_cnt = perf;
`else
    exp_cnt = 32'd0;
`endif
    chk("stall",     {31'd0, bus.stall}, {31'd0, s});
    chk("cmpa_for",  {29'd0, bus.cmpa_for},  {29'd0, exp_fwd_d(d.rs)});
    chk("cmpb_for",  {29'd0, bus.cmpb_for},  {29'd0, exp_fwd_d(d.rt)});
    chk("ra_for",    {29'd0, bus.ra_for},    {29'd0, exp_fwd_d(d.rs)});
    chk("alua_for",  {29'd0, bus.alua_for},  {29'd0, exp_fwd_e(pipe[0].rs)});
    chk("alub_for",  {29'd0, bus.alub_for},  {29'd0, exp_fwd_e(pipe[0].rt)});
    chk("dm_wd_for", {29'd0, bus.dm_wd_for},
        {29'd0, (pipe[1].rt != 0 && pipe[2].a3 == pipe[1].rt) ? FWD_WD_W : FWD_RF});
    chk("md_busy",   {31'd0, bus.md_busy}, {31'd0, (cyc < busy_until) ? 1'b1 : 1'b0});
    chk("stall_cnt", bus.stall_cnt, exp_cnt);
    if (bus.md_busy === 1'b1) busy_seen++;
    cur_d = d; cur_rst = rst; cur_stall = s;
  endtask

  task automatic advance();
    @(posedge clk);
    if (cur_rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      busy_until = 0;
      perf = '0;
    end else begin
      if (pipe[0].kind == MD_MULT)     busy_until = cyc + 1 + MULT_N;
      else if (pipe[0].kind == MD_DIV) busy_until = cyc + 1 + DIV_N;
      if (cur_stall) perf = perf + 32'd1;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = cur_stall ? d_t'('0) : cur_d;
    end
    cyc++;
  endtask

  // Holds d in D until it is accepted; returns how many cycles it was stalled.
  task automatic issue(input d_t d, output int stalls);
    int n;
    n = 0;
    do begin
      apply_check(d, 1'b0);
      advance();
      n++;
    end while (cur_stall && n < 64);
    if (cur_stall) chk("issue_timeout", 32'd1, 32'd0);
    stalls = n - 1;
  endtask

  d_t nop;
  d_t rd;
  d_t hold_d;
  int ns;

  initial begin
    nop = mk(0, 0, 3, 3, 0, 0, SRC_ALU, 1'b0, MD_NONE);
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    reset = 1'b1;
    bus.rs_D = '0; bus.rt_D = '0; bus.tuse_rs_D = 2'd3; bus.tuse_rt_D = 2'd3;
    bus.a3_D = '0; bus.tnew_D = '0; bus.src_D = '0; bus.md_D = 1'b0; bus.md_kind_D = '0;
    repeat (3) @(posedge clk);

    apply_check(nop, 1'b0);
    chk("rst_stall",     {31'd0, bus.stall}, 32'd0);
    chk("rst_md_busy",   {31'd0, bus.md_busy}, 32'd0);
    chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
    advance();

    // load-use: lw $1 then addu using $1
    issue(mk(0, 0, 3, 3, 1, 2, SRC_MEM, 1'b0, MD_NONE), ns);
    issue(mk(1, 0, 1, 3, 2, 1, SRC_ALU, 1'b0, MD_NONE), ns);
    chk("lu_stalls", 32'(ns), 32'd1);
    apply_check(nop, 1'b0);
    chk("lu_alua", {29'd0, bus.alua_for}, {29'd0, FWD_WD_W});
    advance();

    // ALU result in M feeding a branch compare
    issue(mk(0, 0, 3, 3, 2, 1, SRC_ALU, 1'b0, MD_NONE), ns);
    issue(nop, ns);
    apply_check(mk(2, 0, 0, 3, 0, 0, SRC_ALU, 1'b0, MD_NONE), 1'b0);
    chk("br_cmpa", {29'd0, bus.cmpa_for}, {29'd0, FWD_ALU_M});
    chk("br_stall", {31'd0, bus.stall}, 32'd0);
    advance();

    // jal then jr $31
    issue(mk(0, 0, 3, 3, 31, 0, SRC_PC8, 1'b0, MD_NONE), ns);
    apply_check(mk(31, 0, 0, 3, 0, 0, SRC_ALU, 1'b0, MD_NONE), 1'b0);
    chk("jr_ra_e", {29'd0, bus.ra_for}, {29'd0, FWD_PC8_E});
    chk("jr_stall", {31'd0, bus.stall}, 32'd0);
    advance();
    apply_check(mk(31, 0, 0, 3, 0, 0, SRC_ALU, 1'b0, MD_NONE), 1'b0);
    chk("jr_ra_m", {29'd0, bus.ra_for}, {29'd0, FWD_PC8_M});
    advance();

    // register zero never forwards or stalls
    issue(mk(0, 0, 3, 3, 0, 1, SRC_ALU, 1'b0, MD_NONE), ns);
    apply_check(mk(0, 0, 0, 0, 0, 1, SRC_ALU, 1'b0, MD_NONE), 1'b0);
    chk("z_cmpa", {29'd0, bus.cmpa_for}, 32'd0);
    chk("z_cmpb", {29'd0, bus.cmpb_for}, 32'd0);
    chk("z_stall", {31'd0, bus.stall}, 32'd0);
    advance();

    // mult followed immediately by mfhi
    issue(mk(1, 2, 0, 0, 0, 0, SRC_ALU, 1'b1, MD_MULT), ns);
    busy_seen = 0;
    issue(mk(0, 0, 3, 3, 3, 1, SRC_ALU, 1'b1, MD_NONE), ns);
    chk("mult_stalls", 32'(ns), 32'(MULT_N + 1));
    chk("mult_busy_cycles", 32'(busy_seen), 32'(MULT_N));

    // reset three cycles into a divide
    issue(mk(1, 2, 0, 0, 0, 0, SRC_ALU, 1'b1, MD_DIV), ns);
    repeat (2) begin apply_check(nop, 1'b0); advance(); end
    apply_check(nop, 1'b1);
    advance();
    apply_check(mk(0, 0, 3, 3, 3, 1, SRC_ALU, 1'b1, MD_NONE), 1'b0);
    chk("rdiv_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("rdiv_stall", {31'd0, bus.stall}, 32'd0);
    advance();

    // random traffic; a stalled instruction is re-presented until accepted
    cur_stall = 1'b0;
    hold_d = nop;
    for (int i = 0; i < 800; i++) begin
      rd = cur_stall ? hold_d : rand_inst();
      hold_d = rd;
      apply_check(rd, ($urandom_range(0, 127) == 0) ? 1'b1 : 1'b0);
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard controller for the 5-stage pipeline.
- Tracks the destination register, remaining latency (Tnew) and result source of every in-flight instruction in E/M/W.
- Drives the 3-bit select of every forwarding mux and the pipeline stall.
- Owns the multiply/divide busy counter that stalls HI/LO-class instructions.

Parameters:
- MULT_CYCLES, 5, E-stage busy cycles after a mult/multu issue.
- DIV_CYCLES, 10, E-stage busy cycles after a div/divu issue.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous active-high reset
- rs_D  in  5  rs field of instruction in D
- rt_D  in  5  rt field of instruction in D
- tuse_rs_D  in  2  cycles until D instruction consumes rs (3 = never)
- tuse_rt_D  in  2  cycles until D instruction consumes rt (3 = never)
- a3_D  in  5  destination register of D instruction (0 = none)
- tnew_D  in  2  Tnew measured at E entry: link 0, ALU 1, load 2
- src_D  in  2  result source: 00 ALU, 01 memory, 10 PC8
- md_D  in  1  D instruction uses mult/div unit or HI/LO
- md_kind_D  in  2  00 none, 01 mult/multu, 10 div/divu
- stall  out  1  freeze PC and F/D, insert bubble into E
- cmpa_for, cmpb_for, ra_for  out  3 each  D-stage forward selects
- alua_for, alub_for  out  3 each  E-stage forward selects
- dm_wd_for  out  3  M-stage store-data forward select
- md_busy  out  1  mult/div unit busy
- stall_cnt  out  32  stall cycle count (see Optional Feature)

Behaviour:
- Reset, synchronous, all active-high:
  - E/M/W records cleared: a3=0, tnew=0, src=00, rs/rt=0.
  - Busy counter = 0.
  - All outputs: stall=0, all *_for=3'b000, md_busy=0, stall_cnt=0.
  - Reset mid-multiply aborts the busy count.
- Select codes, fixed:
  - 000 own register/pipeline value
  - 001 ALUResult_MEM
  - 010 WD_WB
  - 100 PC8_EX
  - 101 PC8_MEM
  - 110 PC8_WB
  - Codes 011 and 111 are never driven.
- Record advance, each clk with no reset:
  - W <= M.
  - M <= E with tnew = max(tnew-1, 0).
  - E <= D fields when stall=0, or a bubble (a3=0) when stall=1.
  - W tnew is always 0.
- D-stage forwarding (cmpa/ra use rs_D, cmpb uses rt_D):
  - Match requires a3 != 0 and a3 == reg; reg == 0 never forwards.
  - Priority E > M > W.
  - E match with tnew_E==0 and src PC8 -> 100.
  - M match with tnew_M==0: src ALU -> 001, src PC8 -> 101.
  - W match: src PC8 -> 110, otherwise 010.
  - A match whose tnew is not 0 suppresses forwarding from older stages. The stall covers it.
  - ra_for is identical to cmpa_for.
- E-stage forwarding (alua/alub use recorded rs_E/rt_E):
  - Priority M > W.
  - M ALU -> 001, M PC8 -> 101.
  - W -> 010.
- M-stage forwarding (dm_wd on recorded rt_M): W match -> 010.
- Stall, combinational, any true condition:
  - For rs_D or rt_D, with a matching E record: tuse < tnew_E.
  - With a matching M record: tuse < tnew_M.
  - md_D=1 and (md_busy=1 or md_kind_E != 00).
- Busy counter:
  - On advance of an E record with md_kind 01/10, load MULT_CYCLES/DIV_CYCLES.
  - Decrement to 0; md_busy = (count != 0).
  - A new load while nonzero cannot occur because of the stall.
- Latency: all outputs are combinational from inputs plus registered records; records update one cycle after their D inputs.

Optional Feature:
- HAZARD_PERF_EN defined: stall_cnt increments by 1 every cycle stall=1 and wraps at 2^32. It is cleared by reset.
- HAZARD_PERF_EN undefined: stall_cnt is tied to 32'd0 and no counter flops exist.

Decomposition:
- hazard_pkg holds:
  - forward-code constants FWD_RF, FWD_ALU_M, FWD_WD_W, FWD_PC8_E, FWD_PC8_M, FWD_PC8_W
  - src encodings SRC_ALU, SRC_MEM, SRC_PC8
  - md_kind encodings
  - TUSE_NEVER = 2'd3
- Sub-module md_busy_tracker contains the counter, its load/decrement logic and md_busy.

Test Plan:
- Load-use: lw $1 (tnew 2) in E, then addu using $1 (tuse_rs 1) in D -> stall=1 one cycle, then alua_for=010 once lw is in W.
- ALU-to-branch: addu $2 in M (tnew 0), beq $2 in D (tuse 0) -> stall=0, cmpa_for=001.
- jal then jr $31: jal in E (src PC8, tnew 0), jr in D -> ra_for=100 with no stall; one cycle later ra_for=101 if still in D.
- Register zero: a3_E=0 with rs_D=0 -> all selects 000, stall=0.
- Multiply: mult issued (MULT_CYCLES=5), mfhi in D on next cycle -> md_busy high 5 cycles and stall high until md_busy falls; with HAZARD_PERF_EN, stall_cnt equals stalled cycles.
- Reset mid-div: assert reset 3 cycles after div issue -> next cycle md_busy=0, stall=0, all records cleared.
